boot_run_monitor: RTL and testbench

// - Synthesisable successor to the bench-only program preload and cycle/instruction tally around proc.
// - Streams an (addr,data) program image into processor RAM via a write port, holding the core in reset.
// - Then releases the core and counts cycles and retired instructions.
// - Stops on halt or a programmable cycle budget; reports results, restartable without global reset.

---
 rtl/boot_run_monitor_pkg.sv | 17 +
 rtl/boot_run_monitor_if.sv | 28 ++
 rtl/boot_run_monitor_sat_counter.sv | 22 ++
 rtl/boot_run_monitor.sv | 139 +++++++++++++
 tb/tb_boot_run_monitor.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_run_monitor_pkg.sv
// Shared types and default widths for the boot/run monitor.
package boot_run_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_MAX_CYCLES = 100000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/boot_run_monitor_if.sv
// Image-stream and RAM write-port bundle; slave side is the monitor.
interface boot_run_monitor_if
    import boot_run_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              img_valid;
    logic              img_last;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_data;
    logic              img_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output img_valid, img_last, img_addr, img_data,
        input  img_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  img_valid, img_last, img_addr, img_data,
        output img_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/boot_run_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/boot_run_monitor.sv
// Preloads a program image into processor RAM, then runs the core and tallies
// cycles and retired instructions until halt or the cycle budget runs out.
module boot_run_monitor
    import boot_run_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    boot_run_monitor_if.slave    bus,
    output logic                 proc_rst,
    input  logic                 inst_retire,
    input  logic                 proc_halt,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [ADDR_W:0]      load_count,
    output logic [CNT_W-1:0]     total_cycles,
    output logic [CNT_W-1:0]     total_instructions
);

    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_img_ready;
    logic              w_start_ok;
    logic              w_beat;
    logic              w_in_run;
    logic              w_budget_hit;
    logic              r_mem_we_p1;
    logic [ADDR_W-1:0] r_mem_addr_p1;
    logic [DATA_W-1:0] r_mem_wdata_p1;

    assign w_start_ok   = start && (r_state == IDLE || r_state == DONE);
    assign w_beat       = bus.img_valid && w_img_ready;
    assign w_in_run     = (r_state == RUN);
    assign w_budget_hit = (total_cycles == BUDGET_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = LOAD;
            LOAD:    if (w_beat && bus.img_last) w_next = DRAIN;
            DRAIN:   w_next = RUN;
            RUN:     if (proc_halt || w_budget_hit) w_next = DONE;
            DONE:    if (w_start_ok) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_img_ready = 1'b0;
        proc_rst    = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            LOAD: begin
                w_img_ready = 1'b1;
                busy        = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            RUN: begin
                proc_rst = 1'b0;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Write stage: every accepted beat becomes a RAM write exactly one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we_p1    <= 1'b0;
            r_mem_addr_p1  <= '0;
            r_mem_wdata_p1 <= '0;
        end else begin
            r_mem_we_p1 <= w_beat;
            if (w_beat) begin
                r_mem_addr_p1  <= bus.img_addr;
                r_mem_wdata_p1 <= bus.img_data;
            end
        end
    end

    assign bus.img_ready = w_img_ready;
    assign bus.mem_we    = r_mem_we_p1;
    assign bus.mem_addr  = r_mem_addr_p1;
    assign bus.mem_wdata = r_mem_wdata_p1;

    // Halt takes priority over the budget when both land on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timed_out <= 1'b0;
        end else if (w_start_ok) begin
            timed_out <= 1'b0;
        end else if (w_in_run && w_budget_hit && !proc_halt) begin
            timed_out <= 1'b1;
        end
    end

    sat_counter #(.W(ADDR_W + 1)) u_load_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_ok),
        .en  (w_beat),
        .q   (load_count)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_ok),
        .en  (w_in_run),
        .q   (total_cycles)
    );

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_ok),
        .en  (w_in_run && inst_retire),
        .q   (total_instructions)
    );

endmodule

// File: tb/tb_boot_run_monitor.sv
// Directed bench for boot_run_monitor with a 16-cycle run budget.
module tb_boot_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        inst_retire;
    logic        proc_halt;
    logic        proc_rst;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [8:0]  load_count;
    logic [31:0] total_cycles;
    logic [31:0] total_instructions;

    int n_checks = 0;
    int n_fails  = 0;

    boot_run_monitor_if #(.ADDR_W(8), .DATA_W(32)) b ();

    boot_run_monitor #(
        .ADDR_W     (8),
        .DATA_W     (32),
        .CNT_W      (32),
        .MAX_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .bus                (b),
        .proc_rst           (proc_rst),
        .inst_retire        (inst_retire),
        .proc_halt          (proc_halt),
        .busy               (busy),
        .done               (done),
        .timed_out          (timed_out),
        .load_count         (load_count),
        .total_cycles       (total_cycles),
        .total_instructions (total_instructions)
    );

    always #5 clk = ~clk;

    // RAM model plus logs of write and beat-acceptance cycles.
    logic [31:0] ram [0:255];
    int          cyc = 0;
    int          wr_cyc_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          beat_cyc_q[$];

    always @(posedge clk) begin
        if (b.mem_we) begin
            ram[b.mem_addr] <= b.mem_wdata;
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(b.mem_addr);
            wr_data_q.push_back(b.mem_wdata);
        end
        if (b.img_valid && b.img_ready) beat_cyc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [31:0] d, input logic l);
        b.img_valid = 1'b1;
        b.img_addr  = a;
        b.img_data  = d;
        b.img_last  = l;
        tick();
        b.img_valid = 1'b0;
        b.img_last  = 1'b0;
    endtask

    task automatic load_one_and_run(input logic [7:0] a, input logic [31:0] d);
        start_pulse();
        beat(a, d, 1'b1);
        tick();
    endtask

    int w0;
    int b0;
    logic [7:0] t2_addr [4];
    logic [7:0] t6_addr [3];
    logic [31:0] t6_data [3];

    initial begin
        rst = 1'b1; start = 1'b0; inst_retire = 1'b0; proc_halt = 1'b0;
        b.img_valid = 1'b0; b.img_last = 1'b0; b.img_addr = '0; b.img_data = '0;
        t2_addr = '{8'h00, 8'h01, 8'h02, 8'h91};
        t6_addr = '{8'h75, 8'h10, 8'h75};
        t6_data = '{32'h11, 32'hAA, 32'h56};
        repeat (3) tick();

        chk("rst_proc_rst", 64'(proc_rst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(b.img_ready), 64'd0);
        chk("rst_mem_we", 64'(b.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(b.mem_addr), 64'd0);
        chk("rst_cycles", 64'(total_cycles), 64'd0);
        rst = 1'b0;
        tick();

        // Four back-to-back beats, last one on 0x91.
        w0 = wr_cyc_q.size();
        b0 = beat_cyc_q.size();
        start_pulse();
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_ready", 64'(b.img_ready), 64'd1);
        for (int i = 0; i < 4; i++) beat(t2_addr[i], 32'hC0DE_0000 + 32'(i), (i == 3));
        chk("t2_ready_drop", 64'(b.img_ready), 64'd0);
        chk("t2_proc_rst_drain", 64'(proc_rst), 64'd1);
        tick();
        chk("t2_proc_rst_run", 64'(proc_rst), 64'd0);
        chk("t2_load_count", 64'(load_count), 64'd4);
        chk("t2_nwrites", 64'(wr_cyc_q.size() - w0), 64'd4);
        if (wr_cyc_q.size() >= w0 + 4 && beat_cyc_q.size() >= b0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_wr_lat", 64'(wr_cyc_q[w0 + i]), 64'(beat_cyc_q[b0 + i] + 1));
                chk("t2_wr_b2b", 64'(wr_cyc_q[w0 + i] - wr_cyc_q[w0]), 64'(i));
                chk("t2_wr_addr", 64'(wr_addr_q[w0 + i]), 64'(t2_addr[i]));
            end
        end
        chk("t2_ram91", 64'(ram[8'h91]), 64'hC0DE_0003);
        proc_halt = 1'b1;
        tick();
        proc_halt = 1'b0;
        chk("t2_done", 64'(done), 64'd1);

        // Retire every 2nd cycle, halt on run cycle 10.
        load_one_and_run(8'h20, 32'h1234);
        for (int n = 1; n <= 10; n++) begin
            inst_retire = (n % 2 == 0);
            proc_halt   = (n == 10);
            tick();
        end
        inst_retire = 1'b0;
        proc_halt   = 1'b0;
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_timed_out", 64'(timed_out), 64'd0);
        chk("t3_cycles", 64'(total_cycles), 64'd10);
        chk("t3_instr", 64'(total_instructions), 64'd5);
        inst_retire = 1'b1;
        proc_halt   = 1'b1;
        repeat (2) tick();
        inst_retire = 1'b0;
        proc_halt   = 1'b0;
        chk("t3_retire_ignored", 64'(total_instructions), 64'd5);
        chk("t3_still_done", 64'(done), 64'd1);

        // Budget of 16 with no halt.
        load_one_and_run(8'h21, 32'h5678);
        repeat (15) tick();
        chk("t4_not_done", 64'(done), 64'd0);
        chk("t4_cycles15", 64'(total_cycles), 64'd15);
        tick();
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_timed_out", 64'(timed_out), 64'd1);
        chk("t4_cycles", 64'(total_cycles), 64'd16);
        chk("t4_proc_rst", 64'(proc_rst), 64'd1);
        tick();
        chk("t4_frozen", 64'(total_cycles), 64'd16);

        // Halt coinciding with the budget; start during RUN ignored.
        load_one_and_run(8'h22, 32'h9ABC);
        for (int n = 1; n <= 16; n++) begin
            start     = (n == 3);
            proc_halt = (n == 16);
            tick();
            if (n == 3) begin
                chk("t5_start_ign_busy", 64'(busy), 64'd1);
                chk("t5_start_ign_cyc", 64'(total_cycles), 64'd3);
                chk("t5_start_ign_lc", 64'(load_count), 64'd1);
            end
        end
        start     = 1'b0;
        proc_halt = 1'b0;
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_timed_out", 64'(timed_out), 64'd0);
        chk("t5_cycles", 64'(total_cycles), 64'd16);
        start_pulse();
        chk("t5_clr_cycles", 64'(total_cycles), 64'd0);
        chk("t5_clr_lc", 64'(load_count), 64'd0);
        chk("t5_clr_done", 64'(done), 64'd0);
        chk("t5_reload", 64'(b.img_ready), 64'd1);

        // Gappy beats with a duplicate address.
        w0 = wr_cyc_q.size();
        beat(8'h75, 32'h11, 1'b0);
        repeat (2) tick();
        beat(8'h10, 32'hAA, 1'b0);
        tick();
        beat(8'h75, 32'h56, 1'b1);
        tick();
        chk("t6_load_count", 64'(load_count), 64'd3);
        chk("t6_nwrites", 64'(wr_cyc_q.size() - w0), 64'd3);
        if (wr_cyc_q.size() >= w0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t6_wr_addr", 64'(wr_addr_q[w0 + i]), 64'(t6_addr[i]));
                chk("t6_wr_data", 64'(wr_data_q[w0 + i]), 64'(t6_data[i]));
            end
        end
        chk("t6_ram75", 64'(ram[8'h75]), 64'h56);
        chk("t6_ram10", 64'(ram[8'h10]), 64'hAA);

        // Reset mid-RUN.
        inst_retire = 1'b1;
        repeat (3) tick();
        inst_retire = 1'b0;
        chk("t1_pre_instr", 64'(total_instructions), 64'd3);
        rst = 1'b1;
        #1;
        chk("t1_proc_rst", 64'(proc_rst), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_cycles", 64'(total_cycles), 64'd0);
        chk("t1_instr", 64'(total_instructions), 64'd0);
        chk("t1_mem_we", 64'(b.mem_we), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-LOAD with a write pending.
        start_pulse();
        b.img_valid = 1'b1; b.img_addr = 8'h33; b.img_data = 32'hDEAD;
        tick();
        b.img_valid = 1'b0;
        chk("t1l_we_pending", 64'(b.mem_we), 64'd1);
        w0 = wr_cyc_q.size();
        rst = 1'b1;
        #1;
        chk("t1l_mem_we", 64'(b.mem_we), 64'd0);
        chk("t1l_load_count", 64'(load_count), 64'd0);
        chk("t1l_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        chk("t1l_no_write", 64'(wr_cyc_q.size() - w0), 64'd0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
